// File: rtl/snap_trig_capture_ctrl_pkg.sv
// Shared definitions for the snapshot capture controller: FSM states, control
// word and status word bit positions, and the status packing helper.
package snap_trig_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SRC = 1;
    localparam int CTRL_WE_MODE  = 2;

    localparam int STAT_DONE  = 31;
    localparam int STAT_CAPT  = 30;
    localparam int STAT_ARMED = 29;

    // The word count sits in the low bits; it never reaches the flag bits.
    function automatic logic [31:0] pack_status(input state_e st, input logic [31:0] cnt);
        logic [31:0] s;
        s             = cnt;
        s[STAT_DONE]  = (st == ST_DONE);
        s[STAT_CAPT]  = (st == ST_CAPTURE);
        s[STAT_ARMED] = (st == ST_ARMED);
        return s;
    endfunction

endpackage

// File: rtl/snap_trig_capture_ctrl_edge_det.sv
// Rising-edge detector for the software arm bit. The registered copy is held low
// in reset, so an arm bit already high at reset release gives exactly one pulse.
module snap_arm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic arm_level,
    output logic arm_pulse
);

    logic arm_q;
    logic arm_d;

    always_comb begin
        arm_d     = arm_level;
        arm_pulse = arm_level & ~arm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= arm_d;
        end
    end

endmodule

// File: rtl/snap_trig_capture_ctrl.sv
// Snapshot capture controller: arms on a software edge, waits for a trigger,
// then writes 2**ADDR_W samples into the snapshot BRAM and reports status.
module snap_trig_capture_ctrl
    import snap_trig_capture_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl_reg,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              ext_trig,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic [31:0]       status
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       status_q, status_d;

    logic arm_pulse;
    logic trig;
    logic qualified;
    logic write_en;
    logic last_write;
    logic unused_ctrl;

    assign unused_ctrl = ^ctrl_reg[31:3];

    snap_arm_edge_det u_arm_edge (
        .clk       (user_clk),
        .rst       (user_rst),
        .arm_level (ctrl_reg[CTRL_ARM]),
        .arm_pulse (arm_pulse)
    );

    // A fresh arm edge wins over both the trigger and a pending final write.
    always_comb begin
        trig       = ~ctrl_reg[CTRL_TRIG_SRC] | ext_trig;
        qualified  = ctrl_reg[CTRL_WE_MODE] | din_valid;
        write_en   = ((state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & trig))
                     & qualified & ~arm_pulse;
        last_write = write_en & (count_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

        state_d = state_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_pulse) begin
                    state_d = ST_ARMED;
                    count_d = '0;
                end
            end
            ST_ARMED: begin
                if (arm_pulse) begin
                    count_d = '0;
                end else if (trig) begin
                    state_d = last_write ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (arm_pulse) begin
                    state_d = ST_ARMED;
                    count_d = '0;
                end else if (last_write) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (write_en && (count_q != DEPTH)) begin
            count_d = count_q + 1'b1;
        end

        we_d     = write_en;
        addr_d   = write_en ? count_q[ADDR_W-1:0] : addr_q;
        data_d   = write_en ? din : data_q;
        status_d = pack_status(state_d, 32'(count_d));
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_data = data_q;
    assign status    = status_q;

endmodule
